// File: rtl/test_ctrl_pkg.sv
// Shared definitions for the test-controller front end: the button event FSM
// state encoding and a millisecond-to-cycle conversion helper.
package test_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRESS1    = 3'd1,
    ST_WAIT2     = 3'd2,
    ST_PRESS2    = 3'd3,
    ST_LONG_HELD = 3'd4
  } btn_state_e;

  // Clock cycles in a span of ms milliseconds at freq_mhz MHz.
  function automatic int unsigned ms_to_cycles(input int unsigned ms,
                                                input int unsigned freq_mhz);
    return ms * 1000 * freq_mhz;
  endfunction

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// One-register edge detector for an already-synchronous level. The reset
// value of the delayed level is a parameter so a level that is high through
// reset can be made to produce no rising edge.
module edge_detect #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic rise,
  output logic fall
);

  logic level_d;

  // Previous-cycle copy of the level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= RST_VAL;
    else     level_d <= level;
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/btn_event_decoder.sv
// Classifies a debounced button level into single-cycle event pulses:
// press, release, short press, double click, long press and auto-repeat.
module btn_event_decoder
  import test_ctrl_pkg::*;
#(
  parameter int unsigned FREQUENCY = 5,
  parameter int unsigned LONG_MS   = 1000,
  parameter int unsigned DCLICK_MS = 300,
  parameter int unsigned REPEAT_MS = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_press,
  output logic double_click,
  output logic long_press,
  output logic repeat_pulse,
  output logic held
);

  localparam int unsigned T_LONG = ms_to_cycles(LONG_MS, FREQUENCY);
  localparam int unsigned T_DCLK = ms_to_cycles(DCLICK_MS, FREQUENCY);
  localparam int unsigned T_RPT  = ms_to_cycles(REPEAT_MS, FREQUENCY);
  localparam int unsigned CW     = $clog2(max3(T_LONG, T_DCLK, T_RPT) + 1);

  // Terminal counts; each counting state leaves or clears the counter on
  // reaching its terminal value, so the counter can never wrap.
  localparam logic [CW-1:0] LONG_LAST = CW'(T_LONG - 1);
  localparam logic [CW-1:0] DCLK_LAST = CW'(T_DCLK - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(T_RPT - 1);

  logic rise, fall;

  btn_state_e    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          short_nxt, dclick_nxt, long_nxt, rpt_nxt;

  // Delayed level resets high: a button held through reset is ignored until
  // it is released and pressed again.
  edge_detect #(
    .RST_VAL (1'b1)
  ) u_edge (
    .clk   (clk),
    .rst   (rst),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // State, counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_press   <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      press_pulse   <= rise;
      release_pulse <= fall;
      short_press   <= short_nxt;
      double_click  <= dclick_nxt;
      long_press    <= long_nxt;
      repeat_pulse  <= rpt_nxt;
      held          <= level;
    end
  end

  // Next-state, counter and classified-event decode. Edges take priority
  // over timeouts that land in the same cycle.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt + CW'(1);
    short_nxt  = 1'b0;
    dclick_nxt = 1'b0;
    long_nxt   = 1'b0;
    rpt_nxt    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (rise) state_nxt = ST_PRESS1;
      end
      ST_PRESS1: begin
        if (fall) begin
          state_nxt = ST_WAIT2;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = ST_LONG_HELD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end
      end
      ST_WAIT2: begin
        if (rise) begin
          state_nxt  = ST_PRESS2;
          cnt_nxt    = '0;
          dclick_nxt = 1'b1;
        end else if (cnt == DCLK_LAST) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end
      end
      ST_PRESS2: begin
        cnt_nxt = '0;
        if (fall) state_nxt = ST_IDLE;
      end
      ST_LONG_HELD: begin
        if (fall) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == RPT_LAST) begin
          cnt_nxt = '0;
          rpt_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_event_decoder.sv
// Scoreboard bench for btn_event_decoder. A timestamp-based reference model
// predicts every pulse as (edge index, kind) and queues it; a negedge monitor
// pops and compares whenever the DUT pulses.
module tb_btn_event_decoder;

  localparam int T_LONG = 2000;
  localparam int T_DCLK = 1000;
  localparam int T_RPT  = 1000;

  localparam int K_PRESS = 0, K_REL = 1, K_SHORT = 2, K_DCLK = 3, K_LONG = 4, K_RPT = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic level = 1'b0;
  logic press_pulse, release_pulse, short_press, double_click;
  logic long_press, repeat_pulse, held;

  int errors = 0;
  int checks = 0;
  int tnow   = 0;
  logic cur_lv = 1'b0;
  bit mon_en  = 1'b0;
  bit held_ok = 1'b0;
  int exp_q[$];

  btn_event_decoder #(
    .FREQUENCY (1),
    .LONG_MS   (2),
    .DCLICK_MS (1),
    .REPEAT_MS (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .short_press   (short_press),
    .double_click  (double_click),
    .long_press    (long_press),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  always #5 clk = ~clk;

  // Reference model: remembers when the current press began and when the last
  // qualifying release happened, and derives events from elapsed time.
  bit m_prev, m_first, m_second, m_gap;
  int m_rise, m_fall;

  function automatic void model_reset();
    m_prev   = 1'b1;
    m_first  = 1'b0;
    m_second = 1'b0;
    m_gap    = 1'b0;
  endfunction

  function automatic void push_ev(int t, int k);
    exp_q.push_back(t * 8 + k);
  endfunction

  function automatic void model_step(int t, bit v);
    int el;
    if (v && !m_prev) begin
      push_ev(t, K_PRESS);
      if (m_gap && (t - m_fall) <= T_DCLK) begin
        push_ev(t, K_DCLK);
        m_second = 1'b1;
      end else begin
        m_first = 1'b1;
        m_rise  = t;
      end
      m_gap = 1'b0;
    end else if (!v && m_prev) begin
      push_ev(t, K_REL);
      if (m_first && (t - m_rise) <= T_LONG) begin
        m_gap  = 1'b1;
        m_fall = t;
      end
      m_first  = 1'b0;
      m_second = 1'b0;
    end else begin
      if (m_first && v) begin
        el = t - m_rise;
        if (el == T_LONG) push_ev(t, K_LONG);
        else if (el > T_LONG && ((el - T_LONG) % T_RPT) == 0) push_ev(t, K_RPT);
      end
      if (m_gap && (t - m_fall) == T_DCLK) begin
        push_ev(t, K_SHORT);
        m_gap = 1'b0;
      end
    end
    m_prev = v;
  endfunction

  function automatic string kname(int k);
    case (k)
      K_PRESS: return "press_pulse";
      K_REL:   return "release_pulse";
      K_SHORT: return "short_press";
      K_DCLK:  return "double_click";
      K_LONG:  return "long_press";
      default: return "repeat_pulse";
    endcase
  endfunction

  // Monitor: every DUT pulse must match the head of the expected queue.
  always @(negedge clk) begin : monitor
    logic [5:0] obs;
    int e;
    if (mon_en && !rst) begin
      obs = {repeat_pulse, long_press, double_click, short_press, release_pulse, press_pulse};
      while (exp_q.size() > 0 && (exp_q[0] / 8) < tnow) begin
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_%s at edge %0d: got no pulse, expected pulse at edge %0d",
                 kname(e % 8), tnow, e / 8);
      end
      for (int k = 0; k < 6; k++) begin
        if (obs[k]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got pulse at edge %0d, expected none", kname(k), tnow);
          end else begin
            e = exp_q.pop_front();
            if (e != tnow * 8 + k) begin
              errors++;
              $display("FAIL event_%s: got edge %0d kind %s, expected edge %0d kind %s",
                       kname(k), tnow, kname(k), e / 8, kname(e % 8));
            end
          end
        end
      end
      if (held_ok) begin
        checks++;
        if (held !== cur_lv) begin
          errors++;
          $display("FAIL held at edge %0d: got %0b, expected %0b", tnow, held, cur_lv);
        end
      end
    end
  end

  task automatic step(input bit v);
    level = v;
    @(posedge clk);
    tnow++;
    cur_lv  = v;
    held_ok = !rst;
    if (!rst) model_step(tnow, v);
    #1;
  endtask

  task automatic seg(input bit v, input int n);
    repeat (n) step(v);
  endtask

  task automatic do_reset(input bit v, input int n);
    rst     = 1'b1;
    held_ok = 1'b0;
    // A pulse registered on the last edge is wiped by reset before it is seen.
    while (exp_q.size() > 0 && (exp_q[$] / 8) >= tnow) void'(exp_q.pop_back());
    #1;
    checks++;
    if ({press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, held} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b, expected 0000000",
               {press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, held});
    end
    repeat (n) step(v);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input string name);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d outstanding events, expected 0 (next edge %0d)",
               name, exp_q.size(), exp_q[0] / 8);
      exp_q.delete();
    end
  endtask

  initial begin
    bit v;
    int n;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, held} !== 7'b0) begin
      errors++;
      $display("FAIL initial_reset: got %b, expected 0000000",
               {press_pulse, release_pulse, short_press, double_click, long_press, repeat_pulse, held});
    end
    rst = 1'b0;
    model_reset();
    mon_en = 1'b1;

    // Single short press.
    seg(0, 10); seg(1, 50); seg(0, 1100); drain("short");
    // Double click.
    seg(1, 50); seg(0, 200); seg(1, 50); seg(0, 1100); drain("dclick");
    // Long hold with repeats.
    seg(1, 4500); seg(0, 1100); drain("long");
    // Release on the last short-press cycle, and one cycle later.
    seg(1, T_LONG); seg(0, 1100); drain("long_edge");
    seg(1, T_LONG + 1); seg(0, 1100); drain("long_edge1");
    // Second rise on the last window cycle, and one cycle later.
    seg(1, 30); seg(0, T_DCLK); seg(1, 30); seg(0, 1100); drain("dclk_edge");
    seg(1, 30); seg(0, T_DCLK + 1); seg(1, 30); seg(0, 1100); drain("dclk_edge1");
    // Held through reset, then a normal press.
    do_reset(1'b1, 5); seg(1, 100); seg(0, 50); seg(1, 40); seg(0, 1100); drain("held_rst");
    // Reset inside the double-click window.
    seg(1, 40); seg(0, 500); do_reset(1'b0, 3); seg(0, 1200); drain("wait2_rst");
    seg(1, 40); seg(0, 1100); drain("after_rst");

    // Randomized segments clustered around the timing boundaries.
    v = 1'b1;
    for (int i = 0; i < 20; i++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3: n = $urandom_range(1, 300);
        4:          n = $urandom_range(T_DCLK - 2, T_DCLK + 2);
        5:          n = $urandom_range(T_LONG - 2, T_LONG + 2);
        6:          n = $urandom_range(2500, 3600);
        7:          n = $urandom_range(1, 5);
        default:    n = $urandom_range(300, 1200);
      endcase
      seg(v, n);
      if ($urandom_range(0, 11) == 0) do_reset(1'($urandom_range(0, 1)), 2);
      v = ~v;
    end
    seg(0, 1100);
    drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
